vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Schedules the single-port text-mode character VRAM (70 cols x 30 rows, one 8-bit code per cell) between three requesters.
- Requester 1: the VGA display fetch path, which reads one cell per character slot; it always wins.
- Requester 2: the terminal/CPU write port.
- Requester 3: an internal row-clear engine used for scrolling.
- Sits between vga_ctrl-driven character fetch logic and the VRAM macro.

Parameters:
COLS, 70, characters per row
ROWS, 30, character rows
AW, 12, VRAM address width (COLS*ROWS = 2100 < 4096)
DW, 8, character code width
FILL_CHAR, 8'h20, code written by the row-clear engine
FIFO_DEPTH, 4, write FIFO depth (only with VRAM_WR_FIFO_EN)

Ports:
pclk  in  1  25 MHz pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = asserted)
disp_req  in  1  display fetch request, single-cycle pulse
disp_addr  in  AW  cell address = row*COLS + col
disp_data  out  DW  fetched character code
disp_vld  out  1  one-cycle pulse; disp_data is valid
wr_valid  in  1  write request valid
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_addr  in  AW  write cell address
wr_data  in  DW  write character code
clr_start  in  1  start clearing one row, single-cycle pulse
clr_row  in  5  row to clear
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse when the clear finishes
ram_en  out  1  VRAM enable
ram_we  out  1  VRAM write enable
ram_addr  out  AW  VRAM address
ram_wdata  out  DW  VRAM write data
ram_rdata  in  DW  VRAM read data; synchronous, 1-cycle latency

Behaviour:
- Reset values: all outputs 0; clear FSM in IDLE; rr_last = 0; FIFO empty.
- Reset asserted mid-operation aborts any clear in progress. Writes that were never handshaked are lost.
- Arbitration is evaluated each cycle, combinationally from the current requests.
  - disp_req always wins; its read is issued on the ram_* outputs the same cycle.
  - Otherwise the pending write and a pending clear-engine write alternate using rr_last. rr_last = 0 means the write port has priority next. rr_last toggles only when one of them wins while both are pending.
  - A lone requester is granted immediately.
- Display read latency is fixed. disp_req at cycle N gives ram_en=1, ram_we=0 at N; ram_rdata returns at N+1; disp_data is registered and disp_vld=1 at N+2.
- disp_data holds its value until the next disp_vld.
- Back-to-back disp_req on consecutive cycles are each honoured, with the same 2-cycle latency.
- disp_addr >= COLS*ROWS: no RAM access; disp_data=8'h00 with disp_vld at N+2.
- Write port (no FIFO): wr_ready = wr_valid & write grant, combinational. The RAM write happens in the same cycle as the handshake.
- wr_addr >= COLS*ROWS: handshake completes, ram_en stays 0, write dropped.
- Clear FSM states:
  - IDLE -> CLEAR on clr_start when clr_row < ROWS. Latch base = clr_row*COLS (constant multiply; result is AW bits); col counter = 0.
  - IDLE -> DONE on clr_start when clr_row >= ROWS. No writes are issued.
  - CLEAR: requests a write of FILL_CHAR to base+col. On grant, col increments. After the grant at col = COLS-1, go to DONE.
  - DONE: clr_done = 1 for one cycle, then IDLE.
- clr_busy = 1 in CLEAR and DONE.
- clr_start while clr_busy is ignored.
- clr_start is accepted in IDLE even if a write is pending in the same cycle.
- Write and clear targeting the same cell: the RAM holds the value of whichever was granted last.

Optional Feature:
- Macro: VRAM_WR_FIFO_EN.
- Defined:
  - CPU writes enter a FIFO_DEPTH-entry synchronous FIFO; wr_ready = !full, registered.
  - The FIFO head takes part in arbitration in place of wr_valid.
  - Push and pop in the same cycle when full: push accepted (the pop frees a slot). FIFO order is preserved.
- Undefined: the direct combinational handshake described above, with no buffering.

Decomposition:
- Shared package/header holds:
  - COLS, ROWS, FILL_CHAR, AW, DW defaults.
  - Clear FSM state encoding: IDLE=2'd0, CLEAR=2'd1, DONE=2'd2.
- One sub-module: vram_wr_fifo, a generic synchronous FIFO (same active-low async reset). It is instantiated only under VRAM_WR_FIFO_EN.

Test Plan:
1. disp_req with disp_addr=12'd75 and RAM[75]=8'h41 -> ram_en=1, ram_addr=75 at N; disp_vld=1, disp_data=8'h41 at N+2.
2. disp_req and wr_valid (addr 5, data 8'h42) in the same cycle -> display granted, wr_ready=0. Write completes the next cycle with ram_we=1, ram_addr=5.
3. clr_start with clr_row=2, no other traffic -> 70 writes of 8'h20 to addresses 140..209 on consecutive cycles; clr_done pulses one cycle after the last write; clr_busy is low afterwards.
4. Clear running plus continuous wr_valid -> grants alternate write/clear each cycle; the clear takes 140 cycles; every write is handshaked exactly once.
5. clr_row=5'd31 -> clr_done pulses with zero RAM writes. wr_addr=12'd2100 -> handshake completes, ram_en=0.
6. reset driven to 0 during a clear at col=30 -> all outputs 0 asynchronously. After release: FSM in IDLE, no further clear writes, disp_vld=0.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared constants, types and helpers for the text-mode VRAM arbiter.
//   COLS x ROWS character cells, one DW-bit code per cell, AW-bit address.
//   Clear FSM encoding: IDLE=0, CLEAR=1, DONE=2.
// ---------------------------------------------------------------------------
package vram_arbiter_pkg;

    localparam int COLS       = 70;
    localparam int ROWS       = 30;
    localparam int AW         = 12;
    localparam int DW         = 8;
    localparam int CW         = 7;            // column counter width (COLS <= 127)
    localparam int FIFO_DEPTH = 4;
    localparam int CELLS      = COLS * ROWS;  // 2100

    localparam logic [DW-1:0] FILL_CHAR = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    // Cell address lies inside the visible screen.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return a < AW'(CELLS);
    endfunction

    // Row index lies inside the screen.
    function automatic logic row_ok(input logic [4:0] row);
        return row < 5'(ROWS);
    endfunction

    // First cell of a row; product never exceeds 29*70 so AW bits suffice.
    function automatic logic [AW-1:0] row_base(input logic [4:0] row);
        return AW'(row) * AW'(COLS);
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the three requester ports and the VRAM macro port.
//   slave  : arbiter view (takes requests, drives the RAM)
//   master : requester/RAM view (drives requests, returns read data)
// ---------------------------------------------------------------------------
interface vram_arbiter_if;
    import vram_arbiter_pkg::*;

    // display fetch
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_vld;
    // terminal/CPU write
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    // row clear
    logic          clr_start;
    logic [4:0]    clr_row;
    logic          clr_busy;
    logic          clr_done;
    // VRAM macro
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               clr_start, clr_row, ram_rdata,
        output disp_data, disp_vld, wr_ready, clr_busy, clr_done,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               clr_start, clr_row, ram_rdata,
        input  disp_data, disp_vld, wr_ready, clr_busy, clr_done,
               ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/vram_wr_fifo.sv
// ---------------------------------------------------------------------------
// vram_wr_fifo
// Generic synchronous FIFO, asynchronous active-low reset.
//   i_clk, i_rst_n        : clock / reset
//   i_push, i_wdata       : write side (ignored when full unless popping)
//   o_full                : registered-state full flag
//   i_pop, o_rdata        : read side, o_rdata is the current head
//   o_empty               : no entries
// ---------------------------------------------------------------------------
module vram_wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CNTW-1:0]  r_cnt;
    logic             w_push, w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (r_cnt == CNTW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_rdata = r_mem[r_rptr];
    assign w_pop   = i_pop & ~o_empty;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= nxt(r_wptr);
            if (w_pop)  r_rptr <= nxt(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNTW'(1);
                2'b01:   r_cnt <= r_cnt - CNTW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Schedules the single-port character VRAM between display fetch (always
// wins), the CPU write port and the row-clear engine (these two alternate
// round-robin when both are pending).
//   pclk  : pixel clock, rising edge
//   reset : asynchronous, active-low
//   bus   : vram_arbiter_if.slave (display, write, clear and RAM ports)
// Build option VRAM_WR_FIFO_EN: buffer CPU writes in a FIFO_DEPTH FIFO with
// wr_ready = !full; otherwise the handshake is direct and combinational.
// ---------------------------------------------------------------------------
module vram_arbiter
    import vram_arbiter_pkg::*;
(
    input  logic           pclk,
    input  logic           reset,
    vram_arbiter_if.slave  bus
);
    clr_state_e    r_state, w_state_nxt;
    logic [AW-1:0] r_base;
    logic [CW-1:0] r_col;
    logic          r_rr_last;
    logic [1:0]    r_vld_pipe;
    logic          r_disp_ok;
    logic [DW-1:0] r_disp_data;

    logic          w_wr_pend, w_clr_pend, w_clr_load;
    logic          w_disp_gnt, w_wr_gnt, w_clr_gnt;
    wr_req_t       w_wr_req;

`ifdef VRAM_WR_FIFO_EN
    wr_req_t w_fifo_in, w_fifo_head;
    logic    w_fifo_full, w_fifo_empty;

    assign w_fifo_in   = '{addr: bus.wr_addr, data: bus.wr_data};
    assign bus.wr_ready = reset & ~w_fifo_full;

    vram_wr_fifo #(.WIDTH($bits(wr_req_t)), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .i_clk   (pclk),
        .i_rst_n (reset),
        .i_push  (bus.wr_valid & bus.wr_ready),
        .i_wdata (w_fifo_in),
        .o_full  (w_fifo_full),
        .i_pop   (w_wr_gnt),
        .o_rdata (w_fifo_head),
        .o_empty (w_fifo_empty)
    );

    assign w_wr_pend = ~w_fifo_empty;
    assign w_wr_req  = w_fifo_head;
`else
    assign w_wr_pend    = bus.wr_valid;
    assign w_wr_req     = '{addr: bus.wr_addr, data: bus.wr_data};
    assign bus.wr_ready = w_wr_gnt;
`endif

    // Grants are gated by reset so every output reads 0 while it is held.
    assign w_clr_pend = (r_state == CLEAR);
    assign w_disp_gnt = reset & bus.disp_req;
    assign w_wr_gnt   = reset & ~bus.disp_req & w_wr_pend  & (~w_clr_pend | ~r_rr_last);
    assign w_clr_gnt  = reset & ~bus.disp_req & w_clr_pend & (~w_wr_pend  |  r_rr_last);

    // RAM port mux; out-of-range addresses keep the RAM idle.
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (w_disp_gnt) begin
            if (addr_ok(bus.disp_addr)) begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = bus.disp_addr;
            end
        end else if (w_wr_gnt) begin
            if (addr_ok(w_wr_req.addr)) begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = w_wr_req.addr;
                bus.ram_wdata = w_wr_req.data;
            end
        end else if (w_clr_gnt) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = r_base + AW'(r_col);
            bus.ram_wdata = FILL_CHAR;
        end
    end

    // Clear FSM: next state and status outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_clr_load   = 1'b0;
        bus.clr_busy = 1'b0;
        bus.clr_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.clr_start) begin
                    if (row_ok(bus.clr_row)) begin
                        w_state_nxt = CLEAR;
                        w_clr_load  = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            CLEAR: begin
                bus.clr_busy = 1'b1;
                if (w_clr_gnt && r_col == CW'(COLS - 1)) w_state_nxt = DONE;
            end
            DONE: begin
                bus.clr_busy = 1'b1;
                bus.clr_done = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_base <= '0;
            r_col  <= '0;
        end else if (w_clr_load) begin
            r_base <= row_base(bus.clr_row);
            r_col  <= '0;
        end else if (w_clr_gnt) begin
            r_col  <= r_col + CW'(1);
        end
    end

    // rr_last moves only on a contested grant; 1 means clear goes next.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset)                                    r_rr_last <= 1'b0;
        else if (w_wr_pend && w_clr_pend && (w_wr_gnt || w_clr_gnt)) r_rr_last <= w_wr_gnt;
    end

    // Display return: stage 0 waits for the RAM, stage 1 holds registered data.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_vld_pipe  <= '0;
            r_disp_ok   <= 1'b0;
            r_disp_data <= '0;
        end else begin
            r_vld_pipe[0] <= w_disp_gnt;
            r_disp_ok     <= addr_ok(bus.disp_addr);
            r_vld_pipe[1] <= r_vld_pipe[0];
            if (r_vld_pipe[0]) r_disp_data <= r_disp_ok ? bus.ram_rdata : '0;
        end
    end

    assign bus.disp_vld  = r_vld_pipe[1];
    assign bus.disp_data = r_disp_data;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter with a behavioural synchronous VRAM.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    logic pclk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [7:0] mem [0:4095];

    always #5 pclk = ~pclk;

    vram_arbiter_if bus();

    vram_arbiter dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    // synchronous single-port RAM, 1-cycle read latency
    always @(posedge pclk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    task automatic idle_inputs();
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clr_start = 1'b0;
        bus.clr_row   = '0;
    endtask

    task automatic test_reset();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 12'd75;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 12'd5;
        repeat (2) @(negedge pclk);
        #1;
        n_chk++; if (bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en: got %b expected 0", bus.ram_en); end
        n_chk++; if (bus.ram_addr !== 12'd0) begin n_fail++; $display("FAIL reset_ram_addr: got %0d expected 0", bus.ram_addr); end
        n_chk++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 0", bus.wr_ready); end
        n_chk++; if (bus.disp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_disp_vld: got %b expected 0", bus.disp_vld); end
        n_chk++; if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy: got %b expected 0", bus.clr_busy); end
        idle_inputs();
        @(negedge pclk) reset = 1'b1;
        @(negedge pclk);
    endtask

    task automatic test_disp_read();
        mem[75] = 8'h41;
        @(negedge pclk);
        bus.disp_req = 1'b1; bus.disp_addr = 12'd75;
        #1;
        n_chk++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL disp_ram_en_we: got en=%b we=%b expected en=1 we=0", bus.ram_en, bus.ram_we); end
        n_chk++; if (bus.ram_addr !== 12'd75) begin n_fail++; $display("FAIL disp_ram_addr: got %0d expected 75", bus.ram_addr); end
        @(negedge pclk);
        bus.disp_req = 1'b0;
        #1;
        n_chk++; if (bus.disp_vld !== 1'b0) begin n_fail++; $display("FAIL disp_vld_n1: got %b expected 0", bus.disp_vld); end
        @(negedge pclk); #1;
        n_chk++; if (bus.disp_vld !== 1'b1 || bus.disp_data !== 8'h41) begin n_fail++; $display("FAIL disp_data_n2: got vld=%b data=%h expected vld=1 data=41", bus.disp_vld, bus.disp_data); end
        @(negedge pclk); #1;
        n_chk++; if (bus.disp_vld !== 1'b0 || bus.disp_data !== 8'h41) begin n_fail++; $display("FAIL disp_hold: got vld=%b data=%h expected vld=0 data=41", bus.disp_vld, bus.disp_data); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic [7:0]    exp_d [3];
        logic          exp_en[3];
        int bad = 0;
        mem[10] = 8'h11; mem[11] = 8'h22;
        addrs = '{12'd10, 12'd11, 12'd2100};
        exp_d = '{8'h11, 8'h22, 8'h00};
        exp_en = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            bus.disp_req  = (i < 3);
            bus.disp_addr = (i < 3) ? addrs[i] : '0;
            #1;
            if (i < 3 && bus.ram_en !== exp_en[i]) bad++;
            if (i >= 2 && (bus.disp_vld !== 1'b1 || bus.disp_data !== exp_d[i-2])) bad++;
        end
        bus.disp_req = 1'b0;
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL back_to_back: got %0d bad samples expected 0", bad); end
        @(negedge pclk); #1;
        n_chk++; if (bus.disp_vld !== 1'b0 || bus.disp_data !== 8'h00) begin n_fail++; $display("FAIL b2b_tail: got vld=%b data=%h expected vld=0 data=00", bus.disp_vld, bus.disp_data); end
    endtask

    task automatic test_disp_vs_write();
        @(negedge pclk);
        bus.disp_req = 1'b1; bus.disp_addr = 12'd75;
        bus.wr_valid = 1'b1; bus.wr_addr = 12'd5; bus.wr_data = 8'h42;
        #1;
        n_chk++; if (bus.wr_ready !== 1'b0 || bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL dvw_block: got ready=%b we=%b expected 0 0", bus.wr_ready, bus.ram_we); end
        @(negedge pclk);
        bus.disp_req = 1'b0;
        #1;
        n_chk++; if (bus.wr_ready !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 12'd5 || bus.ram_wdata !== 8'h42)
            begin n_fail++; $display("FAIL dvw_write: got ready=%b we=%b addr=%0d data=%h expected 1 1 5 42", bus.wr_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        @(negedge pclk);
        bus.wr_valid = 1'b0;
        #1;
        n_chk++; if (mem[5] !== 8'h42) begin n_fail++; $display("FAIL dvw_mem: got %h expected 42", mem[5]); end
    endtask

    task automatic test_clear();
        int k = 0, bad = 0, done_t = -1;
        @(negedge pclk);
        bus.clr_row = 5'd2; bus.clr_start = 1'b1;
        @(negedge pclk);
        bus.clr_start = 1'b0;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (bus.ram_en && bus.ram_we) begin
                if (int'(bus.ram_addr) != 140 + k || bus.ram_wdata !== 8'h20 || bus.clr_busy !== 1'b1) bad++;
                k++;
            end
            if (bus.clr_done === 1'b1) begin done_t = t; break; end
            @(negedge pclk);
        end
        n_chk++; if (k != 70) begin n_fail++; $display("FAIL clear_writes: got %0d expected 70", k); end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL clear_addr_data: got %0d bad expected 0", bad); end
        n_chk++; if (done_t != 70) begin n_fail++; $display("FAIL clear_done_cycle: got %0d expected 70", done_t); end
        @(negedge pclk); #1;
        n_chk++; if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin n_fail++; $display("FAIL clear_after: got busy=%b done=%b expected 0 0", bus.clr_busy, bus.clr_done); end
    endtask

    task automatic test_clear_vs_write();
        int nw = 0, nc = 0, bad_alt = 0, bad_addr = 0, done_t = -1;
        logic exp_w;
        @(negedge pclk);
        bus.clr_row = 5'd0; bus.clr_start = 1'b1;
        @(negedge pclk);
        bus.clr_start = 1'b0;
        for (int t = 0; t < 300; t++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 12'(1000 + nw);
            bus.wr_data  = 8'(nw);
            #1;
            if (bus.clr_done === 1'b1) begin
                done_t = t;
                if (bus.wr_ready === 1'b1) nw++;
                break;
            end
            exp_w = (t % 2 == 0);
            if (bus.wr_ready !== exp_w) bad_alt++;
            if (bus.wr_ready === 1'b1) begin
                if (int'(bus.ram_addr) != 1000 + nw || bus.ram_we !== 1'b1) bad_addr++;
                nw++;
            end else if (bus.ram_en && bus.ram_we) begin
                if (int'(bus.ram_addr) != nc || bus.ram_wdata !== 8'h20) bad_addr++;
                nc++;
            end
            @(negedge pclk);
        end
        @(negedge pclk);
        bus.wr_valid = 1'b0;
        n_chk++; if (done_t != 140) begin n_fail++; $display("FAIL cvw_done_cycle: got %0d expected 140", done_t); end
        n_chk++; if (nc != 70) begin n_fail++; $display("FAIL cvw_clear_writes: got %0d expected 70", nc); end
        n_chk++; if (nw != 71) begin n_fail++; $display("FAIL cvw_handshakes: got %0d expected 71", nw); end
        n_chk++; if (bad_alt != 0) begin n_fail++; $display("FAIL cvw_alternation: got %0d bad expected 0", bad_alt); end
        n_chk++; if (bad_addr != 0) begin n_fail++; $display("FAIL cvw_addr: got %0d bad expected 0", bad_addr); end
    endtask

    task automatic test_clear_oob();
        @(negedge pclk);
        bus.clr_row = 5'd31; bus.clr_start = 1'b1;
        @(negedge pclk);
        bus.clr_start = 1'b0;
        #1;
        n_chk++; if (bus.clr_done !== 1'b1 || bus.clr_busy !== 1'b1 || bus.ram_en !== 1'b0)
            begin n_fail++; $display("FAIL oob_row_done: got done=%b busy=%b en=%b expected 1 1 0", bus.clr_done, bus.clr_busy, bus.ram_en); end
        @(negedge pclk); #1;
        n_chk++; if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL oob_row_idle: got done=%b busy=%b expected 0 0", bus.clr_done, bus.clr_busy); end
        @(negedge pclk);
        bus.wr_valid = 1'b1; bus.wr_addr = 12'd2100; bus.wr_data = 8'h55;
        #1;
        n_chk++; if (bus.wr_ready !== 1'b1 || bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL oob_write: got ready=%b en=%b expected 1 0", bus.wr_ready, bus.ram_en); end
        @(negedge pclk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_clear_reset();
        logic seen = 1'b0;
        int   nen = 0, nbusy = 0, nvld = 0;
        @(negedge pclk);
        bus.clr_row = 5'd3; bus.clr_start = 1'b1;
        @(negedge pclk);
        bus.clr_start = 1'b0;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (bus.ram_we === 1'b1 && bus.ram_addr === 12'd240) begin seen = 1'b1; break; end
            @(negedge pclk);
        end
        n_chk++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_reach_col30: got %b expected 1", seen); end
        reset = 1'b0;
        #1;
        n_chk++; if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== 12'd0 || bus.ram_wdata !== 8'h00)
            begin n_fail++; $display("FAIL rst_async_ram: got en=%b we=%b addr=%0d data=%h expected all 0", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        n_chk++; if (bus.clr_busy !== 1'b0 || bus.disp_data !== 8'h00) begin n_fail++; $display("FAIL rst_async_state: got busy=%b data=%h expected 0 00", bus.clr_busy, bus.disp_data); end
        @(negedge pclk) reset = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge pclk); #1;
            if (bus.ram_en) nen++;
            if (bus.clr_busy) nbusy++;
            if (bus.disp_vld) nvld++;
        end
        n_chk++; if (nen != 0 || nbusy != 0 || nvld != 0)
            begin n_fail++; $display("FAIL rst_after_release: got en=%0d busy=%0d vld=%0d cycles expected 0 0 0", nen, nbusy, nvld); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        idle_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        test_reset();
        test_disp_read();
        test_back_to_back();
        test_disp_vs_write();
        test_clear();
        test_clear_vs_write();
        test_clear_oob();
        test_clear_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
